// File: rtl/pix_pkg.sv
// Shared frame geometry, widths and the coordinate range check used by the
// pixel read arbiter and its helpers.
package pix_pkg;
  localparam int X_RES  = 60;
  localparam int Y_RES  = 60;
  localparam int xSz    = 6;
  localparam int ySz    = 6;
  localparam int addrSz = 12;
  localparam int colSz  = 3;
  localparam logic [colSz-1:0] BLACK = '0;

  function automatic logic in_range(input int unsigned x, input int unsigned y,
                                    input int unsigned xres, input int unsigned yres);
    return (x < xres) && (y < yres);
  endfunction
endpackage

// File: rtl/address_translator.sv
// Maps an (x,y) pixel coordinate to a linear RAM address y*X_RES + x.
module address_translator #(
  parameter int xSz    = 6,
  parameter int ySz    = 6,
  parameter int addrSz = 12,
  parameter int X_RES  = 60
) (
  input  logic [xSz-1:0]    i_x,
  input  logic [ySz-1:0]    i_y,
  output logic [addrSz-1:0] o_addr
);
  assign o_addr = addrSz'(i_y) * addrSz'(X_RES) + addrSz'(i_x);
endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      int c;
      c = (int'(i_ptr) + i) % NREQ;
      if (!o_any && i_req[c]) begin
        o_any    = 1'b1;
        o_gnt[c] = 1'b1;
        o_idx    = PW'(c);
      end
    end
  end
endmodule

// File: rtl/pixel_read_arbiter.sv
// Round-robin sharing of one single-port pixel RAM among several scan engines;
// grant is same-cycle, pixel returns one cycle later with a per-requester strobe.
module pixel_read_arbiter import pix_pkg::*; #(
  parameter int NREQ   = 2,
  parameter int xSz    = pix_pkg::xSz,
  parameter int ySz    = pix_pkg::ySz,
  parameter int addrSz = pix_pkg::addrSz,
  parameter int colSz  = pix_pkg::colSz,
  parameter int X_RES  = pix_pkg::X_RES,
  parameter int Y_RES  = pix_pkg::Y_RES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*xSz-1:0]   req_x,
  input  logic [NREQ*ySz-1:0]   req_y,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rvalid,
  output logic [colSz-1:0]      rdata,
  output logic [addrSz-1:0]     mem_address,
  input  logic [colSz-1:0]      mem_q
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]     r_ptr;
  logic [NREQ-1:0]   r_vld;
  logic              r_oor;
  logic [addrSz-1:0] r_addr;

  logic [NREQ-1:0]   w_gnt_raw;
  logic [PW-1:0]     w_idx;
  logic              w_any;
  logic              w_grant;
  logic [xSz-1:0]    w_sel_x;
  logic [ySz-1:0]    w_sel_y;
  logic [addrSz-1:0] w_addr;
  logic              w_inr;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt_raw),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Grants are suppressed while reset is held so nothing leaks into the pipe.
  assign w_grant = w_any & ~reset;
  assign gnt     = reset ? '0 : w_gnt_raw;

  assign w_sel_x = req_x[int'(w_idx)*xSz +: xSz];
  assign w_sel_y = req_y[int'(w_idx)*ySz +: ySz];
  assign w_inr   = in_range(32'(w_sel_x), 32'(w_sel_y), X_RES, Y_RES);

  address_translator #(.xSz(xSz), .ySz(ySz), .addrSz(addrSz), .X_RES(X_RES)) u_xlat (
    .i_x    (w_sel_x),
    .i_y    (w_sel_y),
    .o_addr (w_addr)
  );

  assign mem_address = w_grant ? w_addr : r_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr  <= '0;
      r_vld  <= '0;
      r_oor  <= 1'b0;
      r_addr <= '0;
    end else begin
      r_vld <= gnt;
      r_oor <= w_grant & ~w_inr;
      if (w_grant) begin
        r_addr <= w_addr;
        r_ptr  <= (int'(w_idx) == NREQ-1) ? '0 : w_idx + PW'(1);
      end
    end
  end

  // Off-frame reads return black so engines see an edge at the border.
  assign rvalid = r_vld;
  assign rdata  = (|r_vld) ? (r_oor ? colSz'(BLACK) : mem_q) : '0;
endmodule

// File: tb/tb_pixel_read_arbiter.sv
// Randomized and directed checks of pixel_read_arbiter against a cycle-level
// behavioural model of the round-robin read service.
module tb_pixel_read_arbiter;
  localparam int NREQ = 2;

  logic        clk = 0;
  logic        reset;
  logic [1:0]  req;
  logic [11:0] req_x, req_y;
  logic [1:0]  gnt, rvalid;
  logic [2:0]  rdata, mem_q;
  logic [11:0] mem_address;

  pixel_read_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_address(mem_address),
    .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  logic [2:0] ram [0:4095];
  always @(posedge clk) mem_q <= ram[mem_address];

  int errs = 0, checks = 0;
  int m_ptr, m_rv, m_rd, m_last, m_win;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_rv = 0; m_rd = 0; m_last = 0; m_win = -1;
  endtask

  // Called at posedge+1: drive, check at negedge, advance model across the edge.
  task automatic cycle(input logic [1:0] r, input int x0, input int y0,
                       input int x1, input int y1);
    int xs[2], ys[2], eg, ea;
    xs[0] = x0; xs[1] = x1; ys[0] = y0; ys[1] = y1;
    req = r;
    req_x = {6'(x1), 6'(x0)};
    req_y = {6'(y1), 6'(y0)};
    m_win = -1;
    for (int i = 0; i < NREQ; i++)
      if (m_win < 0 && r[(m_ptr + i) % NREQ]) m_win = (m_ptr + i) % NREQ;
    eg = (m_win >= 0) ? (1 << m_win) : 0;
    ea = (m_win >= 0) ? ys[m_win] * 60 + xs[m_win] : m_last;
    #4;
    chk("gnt", int'(gnt), eg);
    chk("mem_address", int'(mem_address), ea);
    chk("rvalid", int'(rvalid), m_rv);
    chk("rdata", int'(rdata), m_rd);
    m_rv = eg;
    if (m_win >= 0) begin
      m_rd   = (xs[m_win] < 60 && ys[m_win] < 60) ? int'(ram[ea]) : 0;
      m_last = ea;
      m_ptr  = (m_win + 1) % NREQ;
    end else
      m_rd = 0;
    @(posedge clk); #1;
  endtask

  int act[2], rx[2], ry[2];

  initial begin
    for (int a = 0; a < 4096; a++) ram[a] = 3'($urandom_range(1, 7));
    ram[125] = 3'd3;
    reset = 1; req = 2'b11; req_x = '0; req_y = '0;
    model_reset();
    @(posedge clk); #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_rvalid", int'(rvalid), 0);
    chk("rst_rdata", int'(rdata), 0);
    chk("rst_addr", int'(mem_address), 0);
    req = 0;
    reset = 0;
    @(posedge clk); #1;

    // single requester
    cycle(2'b01, 5, 2, 0, 0);
    chk("single_rvalid", int'(rvalid), 1);
    chk("single_rdata", int'(rdata), 3);
    cycle(2'b00, 0, 0, 0, 0);
    // contention from ptr=1 after the grant above: 10,01,10,01
    for (int k = 0; k < 4; k++) cycle(2'b11, 10 + k, 4, 20 + k, 7);
    cycle(2'b00, 0, 0, 0, 0);
    // out of range, both axes
    cycle(2'b10, 0, 0, 60, 10);
    chk("oor_x_rdata", int'(rdata), 0);
    cycle(2'b10, 0, 0, 3, 60);
    chk("oor_y_rdata", int'(rdata), 0);
    // abort: ptr at 0 after the grants to 1; grant 0, then 1 while 0 waits, 0 drops
    cycle(2'b01, 1, 1, 0, 0);
    cycle(2'b11, 2, 2, 9, 9);
    cycle(2'b00, 0, 0, 0, 0);
    chk("abort_rvalid", int'(rvalid), 0);
    cycle(2'b10, 0, 0, 8, 8);
    // back-to-back
    for (int k = 0; k < 3; k++) cycle(2'b01, k, 0, 0, 0);
    cycle(2'b00, 0, 0, 0, 0);

    // reset between grant and return
    req = 2'b01; req_x = 12'd7; req_y = 12'd3;
    #4;
    chk("mid_gnt", int'(gnt), int'(2'b01) & {30'd0, 2'b11} & (m_ptr == 0 ? 3 : 1));
    #2 reset = 1;
    #1;
    chk("mid_rst_gnt", int'(gnt), 0);
    chk("mid_rst_addr", int'(mem_address), 0);
    @(posedge clk); #1;
    chk("mid_rst_rvalid", int'(rvalid), 0);
    chk("mid_rst_rdata", int'(rdata), 0);
    req = 0;
    #3 reset = 0;
    model_reset();
    @(posedge clk); #1;
    cycle(2'b11, 4, 4, 5, 5);
    chk("post_rst_first", m_win, 0);

    // randomized traffic obeying the requester rules
    act[0] = 0; act[1] = 0;
    for (int n = 0; n < 400; n++) begin
      logic [1:0] r;
      for (int i = 0; i < 2; i++)
        if (!act[i] && $urandom_range(0, 1) == 1) begin
          act[i] = 1;
          rx[i] = ($urandom_range(0, 5) == 0) ? $urandom_range(56, 63) : $urandom_range(0, 59);
          ry[i] = ($urandom_range(0, 5) == 0) ? $urandom_range(56, 63) : $urandom_range(0, 59);
        end
      r = {act[1] != 0, act[0] != 0};
      cycle(r, rx[0], ry[0], rx[1], ry[1]);
      for (int i = 0; i < 2; i++)
        if (act[i] && m_win == i) act[i] = 0;
        else if (act[i] && $urandom_range(0, 9) == 0) act[i] = 0;
    end
    cycle(2'b00, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
